// File: rtl/mem_req_ctrl.sv
// EXE-to-SRAM-like bus request controller: one op in flight, request one cycle after accept, response one cycle after data_ok.
// Optional MEM_REQ_ALIGN_CHK_EN: flag misaligned half/word ops with rsp_ale and skip the bus.
module mem_req_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_ea,
    output logic        rsp_ale
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;

    localparam logic [2:0] OP_WORD  = 3'd0;
    localparam logic [2:0] OP_BYTE  = 3'd1;
    localparam logic [2:0] OP_HALF  = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_RIGHT = 3'd4;

    logic [2:0]  r_state;
    logic        r_cancel;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [1:0]  r_ea;
    logic        r_ale;
    logic [31:0] r_rdata;

    logic [1:0]  w_ea;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic        w_misalign;

    assign w_ea = req_addr[1:0];

    // Store lanes are pre-shifted here so the bus side only replays registers.
    always_comb begin
        w_size  = 2'd2;
        w_addr  = {req_addr[31:2], 2'b00};
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
        case (req_op)
            OP_BYTE: begin
                w_size  = 2'd0;
                w_addr  = req_addr;
                w_wstrb = 4'b0001 << w_ea;
                w_wdata = {4{req_wdata[7:0]}};
            end
            OP_HALF: begin
                w_size  = 2'd1;
                w_addr  = req_addr;
                w_wstrb = 4'b0011 << w_ea;
                w_wdata = {2{req_wdata[15:0]}};
            end
            OP_LEFT: begin
                w_wstrb = 4'b1111 >> (2'd3 - w_ea);
                w_wdata = req_wdata >> {(2'd3 - w_ea), 3'b000};
            end
            OP_RIGHT: begin
                w_wstrb = 4'b1111 << w_ea;
                w_wdata = req_wdata << {w_ea, 3'b000};
            end
            default: ;
        endcase
        if (!req_wr) begin
            w_wstrb = 4'b0000;
            w_wdata = 32'd0;
        end
    end

`ifdef MEM_REQ_ALIGN_CHK_EN
    assign w_misalign = ((req_op == OP_HALF) && w_ea[0]) ||
                        ((req_op == OP_WORD) && (w_ea != 2'd0));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cancel <= 1'b0;
            r_wr     <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= 32'd0;
            r_wstrb  <= 4'd0;
            r_wdata  <= 32'd0;
            r_ea     <= 2'd0;
            r_ale    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            case (r_state)
                // A flush coinciding with an offered op cancels that op too.
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        r_wr     <= req_wr;
                        r_size   <= w_size;
                        r_addr   <= w_addr;
                        r_wstrb  <= w_wstrb;
                        r_wdata  <= w_wdata;
                        r_ea     <= w_ea;
                        r_ale    <= w_misalign;
                        r_rdata  <= 32'd0;
                        r_cancel <= 1'b0;
                        r_state  <= w_misalign ? S_RESP : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (data_addr_ok) begin
                        r_state  <= (r_cancel || flush) ? S_DISCARD : S_DATA;
                        r_cancel <= 1'b0;
                    end else if (flush) begin
                        r_cancel <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (data_data_ok) begin
                        r_rdata <= r_wr ? 32'd0 : data_rdata;
                        r_state <= flush ? S_IDLE : S_RESP;
                    end else if (flush) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_RESP: begin
                    if (flush || rsp_ready) r_state <= S_IDLE;
                end
                S_DISCARD: begin
                    if (data_data_ok) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign data_req   = (r_state == S_ADDR);
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wstrb = r_wstrb;
    assign data_wdata = r_wdata;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_rdata  = r_rdata;
    assign rsp_ea     = r_ea;
    assign rsp_ale    = r_ale;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed literal cases, then randomized traffic against a transaction-level model.
module tb_mem_req_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_ea;
    logic        rsp_ale;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    mem_req_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_ea(rsp_ea), .rsp_ale(rsp_ale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_BUSA = 1, M_BUSD = 2, M_RESP = 3, M_DRAIN = 4;
    int          m_stage = M_IDLE;
    bit          m_cancel;
    bit          m_wr;
    int          m_op;
    logic [31:0] m_addr, m_wdat, m_rdata;
    bit          m_ale;

    function automatic bit misaligned(int op, logic [1:0] ea);
`ifdef MEM_REQ_ALIGN_CHK_EN
        return (op == 2 && ea[0]) || (op == 0 && ea != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_size(int op);
        return (op == 1) ? 32'd0 : (op == 2) ? 32'd1 : 32'd2;
    endfunction

    function automatic logic [31:0] exp_addr(int op, logic [31:0] a);
        return (op == 1 || op == 2) ? a : (a & 32'hFFFF_FFFC);
    endfunction

    // Which byte lanes a store touches, in memory terms.
    function automatic logic [31:0] exp_strb(bit wr, int op, logic [1:0] ea);
        logic [31:0] s = 0;
        int e = int'(ea);
        if (!wr) return 0;
        for (int i = 0; i < 4; i++) begin
            case (op)
                1: s[i] = (i == e);
                2: s[i] = (i == e) || (i == e + 1);
                3: s[i] = (i <= e);
                4: s[i] = (i >= e);
                default: s[i] = 1'b1;
            endcase
        end
        return s;
    endfunction

    // Which source byte lands on each lane.
    function automatic logic [31:0] exp_wdat(int op, logic [1:0] ea, logic [31:0] d);
        logic [7:0]  b [4];
        logic [31:0] r = 0;
        int e = int'(ea);
        for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        for (int i = 0; i < 4; i++) begin
            case (op)
                1: r[8*i +: 8] = b[0];
                2: r[8*i +: 8] = b[i % 2];
                3: r[8*i +: 8] = (i <= e) ? b[3 - e + i] : 8'h00;
                4: r[8*i +: 8] = (i >= e) ? b[i - e] : 8'h00;
                default: r[8*i +: 8] = b[i];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_stage  = M_IDLE;
            m_cancel = 0;
        end else begin
            case (m_stage)
                M_IDLE: if (req_valid && !flush) begin
                    m_wr = req_wr; m_op = int'(req_op); m_addr = req_addr; m_wdat = req_wdata;
                    m_cancel = 0; m_rdata = 0;
                    m_ale = misaligned(m_op, req_addr[1:0]);
                    m_stage = m_ale ? M_RESP : M_BUSA;
                end
                M_BUSA: begin
                    if (flush) m_cancel = 1;
                    if (data_addr_ok) begin
                        m_stage = m_cancel ? M_DRAIN : M_BUSD;
                        m_cancel = 0;
                    end
                end
                M_BUSD: begin
                    if (data_data_ok) begin
                        m_rdata = m_wr ? 32'd0 : data_rdata;
                        m_stage = flush ? M_IDLE : M_RESP;
                    end else if (flush) m_stage = M_DRAIN;
                end
                M_RESP:  if (flush || rsp_ready) m_stage = M_IDLE;
                M_DRAIN: if (data_data_ok) m_stage = M_IDLE;
                default: m_stage = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(m_stage == M_IDLE));
            check("data_req",  32'(data_req),  32'(m_stage == M_BUSA));
            check("rsp_valid", 32'(rsp_valid), 32'(m_stage == M_RESP));
            if (m_stage == M_BUSA) begin
                check("data_wr",    32'(data_wr),    32'(m_wr));
                check("data_size",  32'(data_size),  exp_size(m_op));
                check("data_addr",  data_addr,       exp_addr(m_op, m_addr));
                check("data_wstrb", 32'(data_wstrb), exp_strb(m_wr, m_op, m_addr[1:0]));
                if (m_wr) check("data_wdata", data_wdata, exp_wdat(m_op, m_addr[1:0], m_wdat));
            end
            if (m_stage == M_RESP) begin
                check("rsp_rdata", rsp_rdata,       m_rdata);
                check("rsp_ea",    32'(rsp_ea),     32'(m_addr[1:0]));
                check("rsp_ale",   32'(rsp_ale),    32'(m_ale));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        req_valid = 0; req_wr = 0; req_op = 0; req_addr = 0; req_wdata = 0; flush = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0; rsp_ready = 0;
    endtask

    task automatic offer(input bit wr, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1; req_wr = wr; req_op = op; req_addr = a; req_wdata = d;
    endtask

    // Store with immediate addr_ok, data_ok next cycle, response taken at once.
    task automatic run_store(input string nm, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] ea_addr,
                             input logic [3:0] strb, input logic [31:0] wd);
        offer(1, op, a, d);
        cyc; req_valid = 0; data_addr_ok = 1;
        @(negedge clk);
        check({nm, "_addr"}, data_addr, ea_addr);
        check({nm, "_strb"}, 32'(data_wstrb), 32'(strb));
        check({nm, "_wdata"}, data_wdata, wd);
        cyc; data_addr_ok = 0; data_data_ok = 1;
        cyc; data_data_ok = 0; rsp_ready = 1;
        @(negedge clk);
        check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        cyc; rsp_ready = 0;
    endtask

    initial begin
        quiet();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_data_req",  32'(data_req),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_data_addr", data_addr,      32'd0);
        check("rst_wstrb",     32'(data_wstrb), 32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'd0);
        check("rst_rsp_ale",   32'(rsp_ale),   32'd0);

        // LW timing: accept c0, addr_ok c2, data_ok c4, response c5
        cyc; offer(0, 3'd0, 32'h1000_0004, 32'd0);
        cyc; req_valid = 0;
        @(negedge clk);
        check("lw_data_req_c1", 32'(data_req), 32'd1);
        check("lw_addr", data_addr, 32'h1000_0004);
        check("lw_size", 32'(data_size), 32'd2);
        cyc; data_addr_ok = 1;
        cyc; data_addr_ok = 0;
        cyc; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("lw_no_rsp_c4", 32'(rsp_valid), 32'd0);
        cyc; data_data_ok = 0; rsp_ready = 1;
        @(negedge clk);
        check("lw_rsp_valid_c5", 32'(rsp_valid), 32'd1);
        check("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("lw_ea", 32'(rsp_ea), 32'd0);
        cyc; rsp_ready = 0;

        run_store("sb", 3'd1, 32'h23, 32'h0000_00A5, 32'h23, 4'b1000, 32'hA5A5_A5A5);
        run_store("swl", 3'd3, 32'h41, 32'h1122_3344, 32'h40, 4'b0011, 32'h0000_1122);
        run_store("swr", 3'd4, 32'h41, 32'h1122_3344, 32'h40, 4'b1110, 32'h2233_4400);

        // Flush during a stalled address phase
        offer(0, 3'd0, 32'h200, 32'd0);
        cyc; req_valid = 0; flush = 1;
        @(negedge clk); check("fl_req_c1", 32'(data_req), 32'd1);
        cyc; flush = 0;
        @(negedge clk); check("fl_req_c2", 32'(data_req), 32'd1);
        cyc;
        @(negedge clk); check("fl_req_c3", 32'(data_req), 32'd1);
        cyc; data_addr_ok = 1;
        cyc; data_addr_ok = 0;
        @(negedge clk);
        check("fl_req_dropped", 32'(data_req), 32'd0);
        check("fl_busy", 32'(req_ready), 32'd0);
        cyc; data_data_ok = 1; data_rdata = 32'h1234_5678;
        cyc; data_data_ok = 0;
        @(negedge clk);
        check("fl_no_rsp", 32'(rsp_valid), 32'd0);
        check("fl_ready", 32'(req_ready), 32'd1);

        // LH at odd address
        offer(0, 3'd2, 32'h3, 32'd0);
        cyc; req_valid = 0;
`ifdef MEM_REQ_ALIGN_CHK_EN
        rsp_ready = 1;
        @(negedge clk);
        check("lh3_no_req", 32'(data_req), 32'd0);
        check("lh3_rsp", 32'(rsp_valid), 32'd1);
        check("lh3_ale", 32'(rsp_ale), 32'd1);
        cyc; rsp_ready = 0;
`else
        data_addr_ok = 1;
        @(negedge clk);
        check("lh3_req", 32'(data_req), 32'd1);
        check("lh3_addr", data_addr, 32'h3);
        check("lh3_size", 32'(data_size), 32'd1);
        check("lh3_ale", 32'(rsp_ale), 32'd0);
        cyc; data_addr_ok = 0; data_data_ok = 1;
        cyc; data_data_ok = 0; rsp_ready = 1;
        cyc; rsp_ready = 0;
`endif

        // Response held off for 4 cycles while a new op is offered
        offer(1, 3'd2, 32'h102, 32'hCAFE_0001);
        cyc; req_valid = 0; data_addr_ok = 1;
        cyc; data_addr_ok = 0; data_data_ok = 1;
        cyc; data_data_ok = 0; offer(0, 3'd1, 32'h301, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_ea", 32'(rsp_ea), 32'd2);
            cyc;
        end
        rsp_ready = 1;
        cyc; rsp_ready = 0;
        @(negedge clk); check("hold_accept", 32'(req_ready), 32'd1);
        cyc; req_valid = 0;
        @(negedge clk);
        check("hold_next_req", 32'(data_req), 32'd1);
        check("hold_next_addr", data_addr, 32'h301);

        // Reset while the new op waits for addr_ok, then a stray data_ok
        cyc; reset = 1;
        cyc; reset = 0; data_data_ok = 1;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_req", 32'(data_req), 32'd0);
        cyc; data_data_ok = 0;
        @(negedge clk); check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            cyc;
            req_valid    = ($urandom_range(0, 2) == 0);
            req_wr       = 1'($urandom_range(0, 1));
            req_op       = 3'($urandom_range(0, 4));
            req_addr     = $urandom;
            req_wdata    = $urandom;
            data_addr_ok = ($urandom_range(0, 2) != 0);
            data_data_ok = ($urandom_range(0, 2) == 0);
            data_rdata   = $urandom;
            rsp_ready    = 1'($urandom_range(0, 1));
            flush        = (m_stage != M_IDLE) && ($urandom_range(0, 15) == 0);
        end
        cyc; quiet();
        repeat (3) cyc;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 EXE side SHALL be: req_valid in 1 op offered; req_ready out 1 op accepted; req_wr in 1 store; req_op in 3 (0 word, 1 byte, 2 half, 3 left LWL/SWL, 4 right LWR/SWR); req_addr in 32; req_wdata in 32; flush in 1 cancel in-flight op.
REQ-003 Bus side (sram-like) SHALL be: data_req out 1; data_wr out 1; data_size out 2; data_addr out 32; data_wstrb out 4; data_wdata out 32; data_addr_ok in 1; data_data_ok in 1; data_rdata in 32.
REQ-004 MEM side SHALL be: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32 raw word; rsp_ea out 2 effective-address low bits; rsp_ale out 1 alignment error.

Function
REQ-005 States SHALL be IDLE, ADDR, DATA, RESP, DISCARD; req_ready = (state==IDLE).
REQ-006 IDLE: req_valid -> capture op fields, next ADDR; misaligned op with check enabled (REQ-020) -> next RESP with rsp_ale=1, no bus request.
REQ-007 ADDR: data_req=1, all data_* outputs held stable from registers; data_addr_ok=1 -> DATA (DISCARD if flush seen).
REQ-008 DATA: data_data_ok=1 -> latch data_rdata (0 for stores), next RESP; data_addr_ok ignored.
REQ-009 RESP: rsp_valid=1, rsp_rdata/rsp_ea/rsp_ale stable; rsp_ready=1 -> IDLE.
REQ-010 flush: in IDLE/RESP -> IDLE, rsp_valid drops next cycle; in ADDR SHALL NOT withdraw data_req, a sticky cancel flag sends addr_ok to DISCARD; in DATA -> DISCARD.
REQ-011 DISCARD: data_req=0, wait data_data_ok, then IDLE; no response produced.
REQ-012 Latency: accept at cycle T -> data_req at T+1; data_data_ok at cycle D -> rsp_valid at D+1; back-to-back addr_ok and data_ok in same cycle SHALL NOT occur for one op (data_ok only counted in DATA).
REQ-013 data_size: byte 0, half 1, word/left/right 2; data_addr = req_addr for byte/half, {req_addr[31:2],2'b00} for word/left/right.
REQ-014 Loads SHALL drive data_wstrb=0000, data_wr=0.
REQ-015 Store wstrb by ea: byte 0001<<ea; half 0011<<ea; word 1111; left ea0..3 = 0001,0011,0111,1111; right ea0..3 = 1111,1110,1100,1000.
REQ-016 Store wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged; left wdata>>(8*(3-ea)); right wdata<<(8*ea).
REQ-017 rsp_ea SHALL equal captured req_addr[1:0] for every op.

Reset
REQ-018 Reset SHALL force state IDLE, cancel flag 0, data_req 0, rsp_valid 0, req_ready 1, all registered data/addr/strb/rdata/ea/ale outputs 0.
REQ-019 Reset mid-transaction SHALL abandon the op with no DISCARD wait; any later stray data_data_ok in IDLE SHALL be ignored.

Configuration
REQ-020 With MEM_REQ_ALIGN_CHK_EN defined, half with ea[0]=1 or word with ea!=0 SHALL set rsp_ale=1 and skip the bus; undefined, rsp_ale SHALL be constant 0 and all ops go to the bus.

Verification
REQ-021 LW addr 0x1000_0004, addr_ok cycle 2, data_ok cycle 4 rdata 0xDEADBEEF -> rsp_valid cycle 5, rsp_rdata 0xDEADBEEF, rsp_ea 0.
REQ-022 SB addr 0x23, wdata 0x0000_00A5 -> data_addr 0x23, size 0, wstrb 1000, wdata 0xA5A5A5A5.
REQ-023 SWL addr 0x41, wdata 0x11223344 -> data_addr 0x40, wstrb 0011, wdata 0x00001122; SWR addr 0x41 -> wstrb 1110, wdata 0x22334400.
REQ-024 LW, flush while in ADDR with addr_ok held low 3 cycles -> data_req stays 1 until addr_ok, then DISCARD, no rsp_valid, req_ready after data_ok.
REQ-025 LH addr 0x3 with MEM_REQ_ALIGN_CHK_EN -> no data_req, rsp_valid next cycle, rsp_ale 1; without macro -> bus request addr 0x3 size 1.
REQ-026 rsp_ready low 4 cycles in RESP -> rsp_* stable, req_ready 0, new req_valid not accepted until handshake.
